// File: rtl/uart_tx_engine.sv
// UART transmit engine: start bit, DATA_WIDTH data bits LSB-first, optional parity, 1 or 2 stop bits.
// Parity support is built only when UART_TX_PARITY_EN is defined; otherwise par_en/par_typ are ignored.
module uart_tx_engine #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stop2,
    output logic                  data_ack,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , PARITY = 3'd4
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  stop2_q, stop2_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  ack_q;
    logic                  accept;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_typ_q, par_typ_d;
`else
    logic unused_par;
    assign unused_par = par_en ^ par_typ;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stop_cnt_d = stop_cnt_q;
        data_d     = data_q;
        stop2_d    = stop2_q;
        accept     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
`endif
        case (state_q)
            IDLE: begin
                if (tick && data_valid) accept = 1'b1;
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (cnt_q == LAST_BIT) begin
                        stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_q ? PARITY : STOP;
`else
                        state_d = STOP;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                end
            end
`endif
            STOP: begin
                // stop_cnt counts completed stop bits; the final one ends when it equals stop2
                if (tick) begin
                    if (stop_cnt_q == stop2_q) begin
                        if (data_valid) accept = 1'b1;
                        else            state_d = IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            state_d    = START;
            data_d     = p_data;
            stop2_d    = stop2;
            cnt_d      = '0;
            stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_d   = par_en;
            par_typ_d  = par_typ;
`endif
        end
    end

    // tx_out is registered from the next state so the line changes on the same edge as the state
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:  tx_d = 1'b0;
            DATA:   tx_d = data_d[cnt_d];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = (^data_d) ^ par_typ_d;
`endif
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            stop_cnt_q <= 1'b0;
            data_q     <= '0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stop_cnt_q <= stop_cnt_d;
            data_q     <= data_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ack_q      <= accept;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
`endif
        end
    end

    assign tx_out   = tx_q;
    assign busy     = busy_q;
    assign data_ack = ack_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: vector table driven into a frame scoreboard plus corner sequences.
module tb_uart_tx_engine;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          tick;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_en;
    logic          par_typ;
    logic          stop2;
    logic          data_ack;
    logic          tx_out;
    logic          busy;

    uart_tx_engine #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .stop2      (stop2),
        .data_ack   (data_ack),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    typedef struct {
        logic [7:0]  data;
        bit          pe;
        bit          pt;
        bit          s2;
        bit          par;   // expected parity bit when parity is used
        int unsigned div;   // tick every div cycles
        bit          b2b;   // next vector follows with no idle gap
    } vec_t;

    typedef struct {
        logic [15:0] bits;
        int unsigned len;
        int unsigned div;
    } frame_t;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned ack_count = 0;
    int unsigned tick_div = 1;
    frame_t      q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned tcnt;
        tick = 1'b0;
        tcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_div <= 1) begin
                tick = 1'b1;
            end else begin
                tick = (tcnt == 0);
                tcnt = (tcnt + 1 >= tick_div) ? 0 : tcnt + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, got, exp, $time);
        end
    endtask

    function automatic frame_t build(input vec_t v);
        frame_t      f;
        int unsigned n;
        f.bits = '1;
        f.bits[0] = 1'b0;
        for (int unsigned i = 0; i < DW; i++) f.bits[1 + i] = v.data[i];
        n = 1 + DW;
        if (v.pe && PAR_BUILT) begin
            f.bits[n] = v.par;
            n++;
        end
        f.bits[n] = 1'b1;
        n++;
        if (v.s2) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.len = n;
        f.div = v.div;
        return f;
    endfunction

    task automatic check_frame(output bit aborted);
        frame_t f;
        aborted = 1'b0;
        ack_count++;
        chk("ack_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() == 0) begin
            aborted = 1'b1;
            return;
        end
        f = q.pop_front();
        for (int unsigned k = 0; k < f.len * f.div; k++) begin
            if (k > 0) @(negedge clk);
            if (!rst_n) begin
                aborted = 1'b1;
                return;
            end
            chk("tx_bit", 32'(tx_out), 32'(f.bits[k / f.div]));
            chk("busy_in_frame", 32'(busy), 32'd1);
            chk("ack_pulse", 32'(data_ack), 32'(k == 0));
        end
    endtask

    // Monitor: each data_ack opens a frame; the cycle after a frame must be idle or a new ack
    initial begin
        bit pend;
        bit ab;
        pend = 1'b0;
        forever begin
            if (!pend) @(negedge clk);
            pend = 1'b0;
            if (rst_n === 1'b1 && data_ack === 1'b1) begin
                check_frame(ab);
                if (!ab) begin
                    @(negedge clk);
                    if (rst_n) begin
                        if (data_ack) begin
                            pend = 1'b1;
                        end else begin
                            chk("post_frame_busy", 32'(busy), 32'd0);
                            chk("post_frame_tx", 32'(tx_out), 32'd1);
                        end
                    end
                end
            end
        end
    end

    task automatic send(input vec_t v);
        bit got;
        p_data     = v.data;
        par_en     = v.pe;
        par_typ    = v.pt;
        stop2      = v.s2;
        data_valid = 1'b1;
        q.push_back(build(v));
        got = 1'b0;
        for (int unsigned n = 0; n < 300; n++) begin
            @(negedge clk);
            if (data_ack) begin
                got = 1'b1;
                break;
            end
        end
        chk("ack_timeout", 32'(got), 32'd1);
    endtask

    task automatic release_inputs();
        data_valid = 1'b0;
        p_data     = 8'($urandom);
        par_en     = 1'($urandom);
        par_typ    = 1'($urandom);
        stop2      = 1'($urandom);
    endtask

    task automatic wait_idle();
        for (int unsigned n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_tx", 32'(tx_out), 32'd1);
    endtask

    initial begin
        vec_t        vecs[10];
        vec_t        v;
        int unsigned acks_before;
        bit          found;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0};
        vecs[2] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0};
        vecs[4] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1};
        vecs[5] = '{8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vecs[6] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 4, 1'b0};
        vecs[7] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b0};
        vecs[8] = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 3, 1'b1};
        vecs[9] = '{8'h6E, 1'b1, 1'b0, 1'b1, 1'b1, 3, 1'b0};

        rst_n      = 1'b0;
        data_valid = 1'b0;
        p_data     = '0;
        par_en     = 1'b0;
        par_typ    = 1'b0;
        stop2      = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_tx", 32'(tx_out), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ack", 32'(data_ack), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_reset_tx", 32'(tx_out), 32'd1);
        chk("idle_after_reset_busy", 32'(busy), 32'd0);

        for (int unsigned i = 0; i < 10; i++) begin
            if (vecs[i].div != tick_div) begin
                tick_div = vecs[i].div;
                repeat (8) @(negedge clk);
            end
            send(vecs[i]);
            if (!vecs[i].b2b) begin
                release_inputs();
                wait_idle();
            end
        end

        // data_valid pulses confined to non-tick cycles must never be accepted
        tick_div = 4;
        repeat (8) @(negedge clk);
        acks_before = ack_count;
        for (int unsigned p = 0; p < 3; p++) begin
            found = 1'b0;
            for (int unsigned n = 0; n < 10; n++) begin
                if (!tick) begin
                    found = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            chk("no_tick_slot_found", 32'(found), 32'd1);
            p_data     = 8'hAA;
            data_valid = 1'b1;
            @(negedge clk);
            data_valid = 1'b0;
        end
        repeat (12) @(negedge clk);
        chk("pulse_no_ack", ack_count, acks_before);
        chk("pulse_busy", 32'(busy), 32'd0);
        chk("pulse_tx", 32'(tx_out), 32'd1);

        // reset during data bit 3 aborts the frame immediately
        tick_div = 1;
        repeat (4) @(negedge clk);
        v = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        send(v);
        release_inputs();
        repeat (4) @(negedge clk);
        chk("pre_reset_bit3", 32'(tx_out), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_tx", 32'(tx_out), 32'd1);
        chk("async_reset_busy", 32'(busy), 32'd0);
        chk("async_reset_ack", 32'(data_ack), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("after_reset_busy", 32'(busy), 32'd0);
        v = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0};
        send(v);
        release_inputs();
        wait_idle();

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Parametrised UART transmit engine: frame controller, shift register, bit counter and parity generator in one block. It accepts a parallel word through a valid/ack handshake and drives a framed serial line: start bit, DATA_WIDTH data bits LSB-first, optional even/odd parity, then 1 or 2 stop bits. It is the successor to the fixed-width TX controller/serializer pair. It adds a baud-tick enable, a runtime stop-bit count and back-to-back frames with no idle gap, and sits between the TX register interface and the pad.

## Interface
- DATA_WIDTH, 8, data bits per frame; legal range 2..16.
- clk  input  1  block clock.
- rst_n  input  1  reset; asynchronous, active-low.
- tick  input  1  bit-period strobe, one clk wide; every state advance happens only on cycles with tick=1.
- p_data  input  DATA_WIDTH  word to send.
- data_valid  input  1  word available.
- par_en  input  1  parity bit enabled for the frame.
- par_typ  input  1  parity type: 0 even, 1 odd.
- stop2  input  1  stop bits: 0 one stop bit, 1 two stop bits.
- data_ack  output  1  one-cycle pulse: word accepted.
- tx_out  output  1  serial line, registered, idle high.
- busy  output  1  frame in progress.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance condition: tick=1 and data_valid=1, and either
  - state=IDLE, or
  - state=STOP on the tick that ends the last stop bit.
- On acceptance:
  - p_data, par_en, par_typ and stop2 are latched.
  - Changes to these inputs during the frame are ignored.
  - State goes to START.
- START: tx_out=0. On the next tick go to DATA with bit counter = 0.
- DATA: tx_out = latched_data[cnt]. On each tick:
  - cnt < DATA_WIDTH-1: increment cnt.
  - cnt = DATA_WIDTH-1: go to PARITY if latched par_en=1, otherwise STOP.
- PARITY:
  - tx_out = XOR of the latched data, XORed with par_typ.
  - On the next tick go to STOP.
- STOP: tx_out=1. The state lasts 1 tick period (stop2=0) or 2 tick periods (stop2=1). On the final tick:
  - Acceptance condition true: go to START (back-to-back, no idle bit).
  - Otherwise: go to IDLE.
- IDLE: tx_out=1.
- data_valid without tick: no effect. The producer holds data_valid until it sees data_ack.
- Illegal state encoding: return to IDLE with tx_out=1 on the next clk.
- Reset values: tx_out=1, busy=0, data_ack=0, state IDLE, counters 0.
- Reset mid-frame: frame aborted; tx_out=1 asynchronously; nothing is resumed.

## Timing
- Acceptance on a tick edge at cycle c. In cycle c+1:
  - tx_out=0 (start bit), busy=1, data_ack=1.
  - data_ack is high for exactly one cycle.
- Each bit is held for exactly one tick period; start-bit duration equals the tick interval.
- Frame length in tick periods: 1 + DATA_WIDTH + par_en + (1 + stop2).
- busy:
  - Rises the cycle after acceptance.
  - Falls in the cycle after the tick that ends the last stop bit, unless a back-to-back acceptance happens on that tick; then busy stays 1 continuously.
- tick asserted every cycle gives one bit per clk.

## Configuration
- UART_TX_PARITY_EN defined:
  - PARITY state and parity logic are built.
  - par_en and par_typ behave as described above.
- Not defined:
  - PARITY state and parity XOR tree are removed.
  - par_en and par_typ remain as ports but are ignored.
  - Frame is always start, data, stop(s).

## Test plan
- UART_TX_PARITY_EN defined, DATA_WIDTH=8, tick every cycle, p_data=0xA5, par_en=1, par_typ=0, stop2=0 -> tx_out sequence 0,1,0,1,0,0,1,0,1,0,1 (11 bits); busy=1 for 11 cycles; data_ack pulses once.
- Same frame with par_typ=1 -> parity bit 1; p_data=0x07, even parity -> parity bit 1.
- par_en=0, stop2=1, p_data=0x00 -> 0, eight 0s, 1,1 (11 bits); back in IDLE afterwards with tx_out=1, busy=0.
- data_valid held high with 0x55 then 0x0F, par_en=0, stop2=0 -> two 10-bit frames with no idle bit between; busy never drops; two data_ack pulses exactly 10 ticks apart.
- tick every 4th cycle, p_data=0x3C -> every bit held 4 cycles; data_valid pulsed between ticks is ignored.
- rst_n low during data bit 3 -> tx_out=1 and busy=0 immediately; next data_valid with tick starts a complete fresh frame.
